// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared state encoding and sizing for the acc_core scheduler
package acc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_WAIT = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  localparam int DEF_IN_DATA_WIDTH = 8;
  localparam int DEF_LANES         = 4;
  localparam int DEF_CNT_WIDTH     = 12;
  localparam int DEF_TIMEOUT       = 1023;

  // Each acc_core returns a double-width accumulation per lane.
  function automatic int res_width(input int in_width);
    return 2 * in_width;
  endfunction

endpackage

// File: rtl/acc_done_tracker.sv
// rtl/acc_done_tracker.sv - sticky per-lane done mask with first-done capture enables
module acc_done_tracker #(
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [LANES-1:0] done_i,
  output logic [LANES-1:0] cap_en_o,
  output logic             all_done_o
);

  logic [LANES-1:0] r_mask;

  // A lane is captured only on its first done cycle, later results are ignored.
  assign cap_en_o   = done_i & ~r_mask & {LANES{enable_i}};
  assign all_done_o = enable_i & (&(r_mask | done_i));

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      r_mask <= '0;
    end else begin
      r_mask <= r_mask | cap_en_o;
    end
  end

endmodule

// File: rtl/acc_core_scheduler.sv
// rtl/acc_core_scheduler.sv - sequences one accumulation job across the acc_core lanes
module acc_core_scheduler
  import acc_pkg::*;
#(
  parameter int IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
  parameter int LANES         = DEF_LANES,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [CNT_WIDTH-1:0]                 len_i,
  output logic                                 busy_o,
  input  logic                                 s_valid_i,
  output logic                                 s_ready_o,
  input  logic [LANES*IN_DATA_WIDTH-1:0]       s_data_i,
  output logic [LANES-1:0]                     lane_valid_o,
  output logic [LANES*IN_DATA_WIDTH-1:0]       lane_number_o,
  output logic                                 lane_run_o,
  input  logic [LANES-1:0]                     lane_done_i,
  input  logic [LANES*2*IN_DATA_WIDTH-1:0]     lane_result_i,
  output logic                                 m_valid_o,
  input  logic                                 m_ready_i,
  output logic [LANES*2*IN_DATA_WIDTH-1:0]     m_data_o,
  output logic                                 err_o,
  output logic [CNT_WIDTH-1:0]                 words_o
);

  localparam int RW = res_width(IN_DATA_WIDTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t                           r_state, w_next;
  logic [CNT_WIDTH-1:0]             r_len, r_words;
  logic [TW-1:0]                    r_tmo;
  logic [LANES-1:0]                 r_lane_valid;
  logic [LANES*IN_DATA_WIDTH-1:0]   r_lane_number;
  logic                             r_run, r_m_valid, r_err;
  logic [LANES*RW-1:0]              r_m_data;

  logic                             w_xfer, w_last, w_start_ok, w_start_bad;
  logic                             w_in_wait, w_all_done, w_timeout;
  logic [LANES-1:0]                 w_cap_en;

  assign w_xfer      = s_valid_i & s_ready_o;
  assign w_last      = w_xfer && ((r_words + CNT_WIDTH'(1)) == r_len);
  assign w_start_ok  = (r_state == ST_IDLE) && start_i && (len_i != '0);
  assign w_start_bad = (r_state == ST_IDLE) && start_i && (len_i == '0);
  assign w_in_wait   = (r_state == ST_WAIT);
  // A done arriving on the terminal count still completes the job.
  assign w_timeout   = w_in_wait && !w_all_done && (r_tmo == TMO_LAST);

  acc_done_tracker #(.LANES(LANES)) u_done (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (r_state == ST_RUN),
    .enable_i   (w_in_wait),
    .done_i     (lane_done_i),
    .cap_en_o   (w_cap_en),
    .all_done_o (w_all_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) w_next = ST_LOAD;
      ST_LOAD: if (w_last) w_next = ST_RUN;
      ST_RUN:  w_next = ST_WAIT;
      ST_WAIT: begin
        if (w_all_done)     w_next = ST_HOLD;
        else if (w_timeout) w_next = ST_IDLE;
      end
      ST_HOLD: if (m_ready_i) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready_o = (r_state == ST_LOAD);
    busy_o    = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len         <= '0;
      r_words       <= '0;
      r_tmo         <= '0;
      r_lane_valid  <= '0;
      r_lane_number <= '0;
      r_run         <= 1'b0;
      r_m_valid     <= 1'b0;
      r_err         <= 1'b0;
      r_m_data      <= '0;
    end else begin
      r_lane_valid <= {LANES{w_xfer}};
      r_run        <= (r_state == ST_RUN);

      if (w_start_ok) begin
        r_len   <= len_i;
        r_words <= '0;
        r_err   <= 1'b0;
      end
      if (w_start_bad || w_timeout) begin
        r_err <= 1'b1;
      end

      if (w_xfer) begin
        r_lane_number <= s_data_i;
        r_words       <= r_words + CNT_WIDTH'(1);
      end

      if (r_state == ST_RUN) begin
        r_tmo <= '0;
      end else if (w_in_wait) begin
        r_tmo <= r_tmo + TW'(1);
      end

      for (int i = 0; i < LANES; i++) begin
        if (w_cap_en[i]) begin
          r_m_data[i*RW +: RW] <= lane_result_i[i*RW +: RW];
        end
      end

      if (w_all_done) begin
        r_m_valid <= 1'b1;
      end else if ((r_state == ST_HOLD) && m_ready_i) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign lane_valid_o  = r_lane_valid;
  assign lane_number_o = r_lane_number;
  assign lane_run_o    = r_run;
  assign m_valid_o     = r_m_valid;
  assign m_data_o      = r_m_data;
  assign err_o         = r_err;
  assign words_o       = r_words;

endmodule

// File: tb/tb_acc_core_scheduler.sv
// tb/tb_acc_core_scheduler.sv - directed bench with job-level reference model for acc_core_scheduler
module tb_acc_core_scheduler;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int C  = 12;
  localparam int T  = 1023;
  localparam int RW = 2 * W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [C-1:0]     len_i;
  logic             busy_o;
  logic             s_valid_i;
  logic             s_ready_o;
  logic [L*W-1:0]   s_data_i;
  logic [L-1:0]     lane_valid_o;
  logic [L*W-1:0]   lane_number_o;
  logic             lane_run_o;
  logic [L-1:0]     lane_done_i;
  logic [L*RW-1:0]  lane_result_i;
  logic             m_valid_o;
  logic             m_ready_i;
  logic [L*RW-1:0]  m_data_o;
  logic             err_o;
  logic [C-1:0]     words_o;

  acc_core_scheduler #(
    .IN_DATA_WIDTH(W), .LANES(L), .CNT_WIDTH(C), .TIMEOUT(T)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i), .busy_o(busy_o),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .lane_valid_o(lane_valid_o), .lane_number_o(lane_number_o), .lane_run_o(lane_run_o),
    .lane_done_i(lane_done_i), .lane_result_i(lane_result_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .err_o(err_o), .words_o(words_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_strobe = 0;
  int n_run = 0;
  bit mv_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Job-level reference: phase of the job, words taken, and per-lane first-done results.
  typedef enum int {P_IDLE, P_LOAD, P_RUN, P_WAIT, P_HOLD} phase_t;
  phase_t       ph = P_IDLE;
  bit           mdl_ok = 0;
  int           e_len, e_words, wait_cycles;
  bit           e_err, e_strobe, e_run, e_mv;
  logic [L*W-1:0]  e_num;
  logic [RW-1:0]   e_res [L];
  bit           got [L];

  function automatic logic [L*RW-1:0] pack_res();
    logic [L*RW-1:0] v;
    for (int l = 0; l < L; l++) v[l*RW +: RW] = e_res[l];
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      ph = P_IDLE; e_len = 0; e_words = 0; e_err = 0; e_strobe = 0; e_run = 0;
      e_mv = 0; e_num = '0; wait_cycles = 0; mdl_ok = 1;
      for (int l = 0; l < L; l++) begin e_res[l] = '0; got[l] = 0; end
    end else begin
      e_strobe = 0;
      e_run = 0;
      case (ph)
        P_IDLE: if (start_i) begin
          if (len_i == 0) e_err = 1;
          else begin e_len = int'(len_i); e_words = 0; e_err = 0; ph = P_LOAD; end
        end
        P_LOAD: if (s_valid_i) begin
          e_num = s_data_i; e_strobe = 1; e_words++;
          if (e_words == e_len) ph = P_RUN;
        end
        P_RUN: begin
          e_run = 1; ph = P_WAIT; wait_cycles = 0;
          for (int l = 0; l < L; l++) got[l] = 0;
        end
        P_WAIT: begin
          int ndone;
          wait_cycles++;
          ndone = 0;
          for (int l = 0; l < L; l++) begin
            if (lane_done_i[l] && !got[l]) begin
              e_res[l] = lane_result_i[l*RW +: RW];
              got[l] = 1;
            end
            if (got[l]) ndone++;
          end
          if (ndone == L) begin e_mv = 1; ph = P_HOLD; end
          else if (wait_cycles == T) begin e_err = 1; ph = P_IDLE; end
        end
        P_HOLD: if (m_ready_i) begin e_mv = 0; ph = P_IDLE; end
        default: ph = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (lane_valid_o == 4'hF) n_strobe <= n_strobe + 1;
    if (lane_run_o) n_run <= n_run + 1;
    if (m_valid_o) mv_seen <= 1;
  end

  initial forever begin
    @(negedge clk);
    if (mdl_ok) begin
      chk("busy", 64'(busy_o), 64'(ph != P_IDLE));
      chk("s_ready", 64'(s_ready_o), 64'(ph == P_LOAD));
      chk("lane_valid", 64'(lane_valid_o), e_strobe ? 64'hF : 64'h0);
      chk("lane_number", 64'(lane_number_o), 64'(e_num));
      chk("lane_run", 64'(lane_run_o), 64'(e_run));
      chk("m_valid", 64'(m_valid_o), 64'(e_mv));
      chk("err", 64'(err_o), 64'(e_err));
      chk("words", 64'(words_o), 64'(e_words));
      if (e_mv) chk("m_data", m_data_o, pack_res());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len);
    start_i = 1'b1;
    len_i = C'(len);
    tick();
    start_i = 1'b0;
    len_i = '0;
  endtask

  task automatic send_word(input logic [L*W-1:0] d);
    bit rdy = 0;
    int k = 0;
    s_valid_i = 1'b1;
    s_data_i = d;
    while (!rdy && k < 50) begin
      @(negedge clk);
      rdy = s_ready_o;
      k++;
      @(posedge clk);
      #1;
    end
    s_valid_i = 1'b0;
    chk("s_ready_wait", 64'(rdy), 64'h1);
  endtask

  task automatic wait_run();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!lane_run_o && k < 100);
    chk("run_pulse_seen", 64'(lane_run_o), 64'h1);
  endtask

  task automatic respond_all(input logic [L*RW-1:0] r);
    wait_run();
    tick();
    tick();
    lane_done_i = 4'hF;
    lane_result_i = r;
    tick();
    lane_done_i = '0;
    lane_result_i = '0;
  endtask

  task automatic finish_job(input logic [L*RW-1:0] r);
    respond_all(r);
    chk("fin_m_valid", 64'(m_valid_o), 64'h1);
    chk("fin_m_data", m_data_o, r);
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    chk("fin_busy", 64'(busy_o), 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst = 1'b1; start_i = 0; len_i = '0; s_valid_i = 0; s_data_i = '0;
    lane_done_i = '0; lane_result_i = '0; m_ready_i = 0;
    tick();
    tick();
    chk("rst_busy", 64'(busy_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);
    chk("rst_m_valid", 64'(m_valid_o), 64'h0);
    chk("rst_words", 64'(words_o), 64'h0);
    rst = 1'b0;

    // Basic job with backpressure in HOLD.
    n_strobe = 0; n_run = 0;
    start_job(3);
    send_word(32'h04030201);
    s_valid_i = 1'b1;
    send_word(32'h08070605);
    send_word(32'h0C0B0A09);
    chk("basic_last_number", 64'(lane_number_o), 64'h0C0B0A09);
    respond_all(64'h0018_0015_0012_000F);
    chk("basic_m_valid", 64'(m_valid_o), 64'h1);
    chk("basic_words", 64'(words_o), 64'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp_m_data", m_data_o, 64'h0018_0015_0012_000F);
      chk("bp_m_valid", 64'(m_valid_o), 64'h1);
      tick();
    end
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    chk("bp_busy_after", 64'(busy_o), 64'h0);
    chk("basic_strobes", 64'(n_strobe), 64'd3);
    chk("basic_runs", 64'(n_run), 64'd1);

    // Staggered done: each lane keeps the value from its own done cycle.
    start_job(1);
    send_word(32'hDDCCBBAA);
    wait_run();
    tick();
    lane_done_i = 4'b0001; lane_result_i = 64'hA3A3_A2A2_A1A1_1111;
    tick();
    lane_done_i = 4'b0100; lane_result_i = 64'hB3B3_3333_B1B1_B0B0;
    chk("stag_mv0", 64'(m_valid_o), 64'h0);
    tick();
    lane_done_i = 4'b1010; lane_result_i = 64'h4444_C2C2_2222_C0C0;
    chk("stag_mv1", 64'(m_valid_o), 64'h0);
    tick();
    lane_done_i = '0; lane_result_i = '0;
    chk("stag_m_valid", 64'(m_valid_o), 64'h1);
    chk("stag_m_data", m_data_o, 64'h4444_3333_2222_1111);
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    chk("stag_busy", 64'(busy_o), 64'h0);

    // Illegal start, then start pulsed mid-LOAD is ignored.
    start_job(0);
    chk("illegal_err", 64'(err_o), 64'h1);
    chk("illegal_busy", 64'(busy_o), 64'h0);
    start_job(2);
    chk("legal_clears_err", 64'(err_o), 64'h0);
    send_word(32'h11223344);
    start_i = 1'b1; len_i = C'(7);
    tick();
    start_i = 1'b0; len_i = '0;
    chk("ign_words", 64'(words_o), 64'd1);
    send_word(32'h55667788);
    chk("ign_words2", 64'(words_o), 64'd2);
    finish_job(64'h0101_0202_0303_0404);

    // Timeout: no lane ever reports done.
    start_job(1);
    send_word(32'h99999999);
    mv_seen = 0;
    wait_run();
    cnt = 1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy_o) break;
      cnt++;
    end
    chk("tmo_wait_cycles", 64'(cnt), 64'd1023);
    chk("tmo_err", 64'(err_o), 64'h1);
    tick();
    chk("tmo_no_m_valid", 64'(mv_seen), 64'h0);
    start_job(1);
    chk("tmo_err_cleared", 64'(err_o), 64'h0);
    send_word(32'h0000_0001);
    finish_job(64'h0001_0001_0001_0001);

    // Reset in the middle of a load.
    start_job(4);
    send_word(32'hAAAA_0001);
    send_word(32'hAAAA_0002);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", 64'(busy_o), 64'h0);
    chk("mid_rst_ready", 64'(s_ready_o), 64'h0);
    chk("mid_rst_lane_valid", 64'(lane_valid_o), 64'h0);
    chk("mid_rst_lane_number", 64'(lane_number_o), 64'h0);
    chk("mid_rst_run", 64'(lane_run_o), 64'h0);
    chk("mid_rst_m_valid", 64'(m_valid_o), 64'h0);
    chk("mid_rst_m_data", m_data_o, 64'h0);
    chk("mid_rst_err", 64'(err_o), 64'h0);
    chk("mid_rst_words", 64'(words_o), 64'h0);
    rst = 1'b0;
    start_job(1);
    send_word(32'h7F7F7F7F);
    chk("post_rst_words", 64'(words_o), 64'd1);
    finish_job(64'h00FE_00FD_00FC_00FB);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
